// File: rtl/io_port_fifo_bank_if.sv
// Datapath-side and stream-side signals of the per-port FIFO bank.
// The master modport is the environment (datapath plus external streams); slave is the bank.
interface io_port_fifo_bank_if #(
    parameter int WORD_WIDTH = 36,
    parameter int PORT_COUNT = 3
);
    logic [PORT_COUNT-1:0]            io_rden;
    logic [PORT_COUNT*WORD_WIDTH-1:0] io_read_data;
    logic [PORT_COUNT-1:0]            io_read_EF;
    logic [PORT_COUNT-1:0]            io_wren;
    logic [PORT_COUNT*WORD_WIDTH-1:0] io_write_data;
    logic [PORT_COUNT-1:0]            io_write_EF;
    logic [PORT_COUNT-1:0]            ext_in_valid;
    logic [PORT_COUNT-1:0]            ext_in_ready;
    logic [PORT_COUNT*WORD_WIDTH-1:0] ext_in_data;
    logic [PORT_COUNT-1:0]            ext_out_valid;
    logic [PORT_COUNT-1:0]            ext_out_ready;
    logic [PORT_COUNT*WORD_WIDTH-1:0] ext_out_data;
    logic                             err_clear;
    logic [PORT_COUNT-1:0]            err_underflow;
    logic [PORT_COUNT-1:0]            err_overflow;

    modport master (
        output io_rden, io_wren, io_write_data, ext_in_valid, ext_in_data, ext_out_ready, err_clear,
        input  io_read_data, io_read_EF, io_write_EF, ext_in_ready, ext_out_valid, ext_out_data,
        input  err_underflow, err_overflow
    );

    modport slave (
        input  io_rden, io_wren, io_write_data, ext_in_valid, ext_in_data, ext_out_ready, err_clear,
        output io_read_data, io_read_EF, io_write_EF, ext_in_ready, ext_out_valid, ext_out_data,
        output err_underflow, err_overflow
    );
endinterface

// File: rtl/io_port_fifo_bank.sv
// Bank of independent show-ahead FIFOs: per port one read FIFO (external producer -> datapath)
// and one write FIFO (datapath -> external consumer), with sticky underflow/overflow flags.
module io_port_fifo_bank #(
    parameter int WORD_WIDTH        = 36,
    parameter int PORT_COUNT        = 3,
    parameter int FIFO_DEPTH        = 4,
    parameter int FIFO_ADDR_WIDTH   = 2,
    parameter int WRITE_FULL_MARGIN = 0
) (
    input  logic                clock,
    input  logic                reset_n,
    io_port_fifo_bank_if.slave  bus
);

    localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE  = FIFO_ADDR_WIDTH'(1);
    localparam logic [FIFO_ADDR_WIDTH:0]   CNT_ONE  = (FIFO_ADDR_WIDTH+1)'(1);
    localparam logic [FIFO_ADDR_WIDTH:0]   CNT_FULL = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH);

    for (genvar p = 0; p < PORT_COUNT; p++) begin : g_port
        logic [WORD_WIDTH-1:0]      rd_mem [FIFO_DEPTH];
        logic [FIFO_ADDR_WIDTH-1:0] rd_rptr, rd_wptr;
        logic [FIFO_ADDR_WIDTH:0]   rd_cnt;
        logic                       rd_push, rd_pop, rd_empty;

        logic [WORD_WIDTH-1:0]      wr_mem [FIFO_DEPTH];
        logic [FIFO_ADDR_WIDTH-1:0] wr_rptr, wr_wptr;
        logic [FIFO_ADDR_WIDTH:0]   wr_cnt, wr_free;
        logic                       wr_push, wr_pop, wr_full;

        logic                       underflow_q, overflow_q;

        // Read FIFO: ready comes from the registered count only, so a pop never frees a slot same-cycle.
        assign rd_empty = (rd_cnt == '0);
        assign rd_push  = bus.ext_in_valid[p] && (rd_cnt != CNT_FULL);
        assign rd_pop   = bus.io_rden[p] && !rd_empty;

        assign bus.ext_in_ready[p]                       = (rd_cnt != CNT_FULL);
        assign bus.io_read_EF[p]                         = !rd_empty;
        assign bus.io_read_data[p*WORD_WIDTH +: WORD_WIDTH] = rd_mem[rd_rptr];

        always_ff @(posedge clock) begin
            if (rd_push) rd_mem[rd_wptr] <= bus.ext_in_data[p*WORD_WIDTH +: WORD_WIDTH];
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                rd_rptr <= '0;
                rd_wptr <= '0;
                rd_cnt  <= '0;
            end else begin
                if (rd_push) rd_wptr <= rd_wptr + PTR_ONE;
                if (rd_pop)  rd_rptr <= rd_rptr + PTR_ONE;
                case ({rd_push, rd_pop})
                    2'b10:   rd_cnt <= rd_cnt + CNT_ONE;
                    2'b01:   rd_cnt <= rd_cnt - CNT_ONE;
                    default: rd_cnt <= rd_cnt;
                endcase
            end
        end

        // Write FIFO: EF may rise early by the margin, but pushes are only refused on true full.
        assign wr_full = (wr_cnt == CNT_FULL);
        assign wr_free = CNT_FULL - wr_cnt;
        assign wr_push = bus.io_wren[p] && !wr_full;
        assign wr_pop  = bus.ext_out_ready[p] && (wr_cnt != '0);

        assign bus.io_write_EF[p]                            = (int'(wr_free) <= WRITE_FULL_MARGIN);
        assign bus.ext_out_valid[p]                          = (wr_cnt != '0);
        assign bus.ext_out_data[p*WORD_WIDTH +: WORD_WIDTH]  = wr_mem[wr_rptr];

        always_ff @(posedge clock) begin
            if (wr_push) wr_mem[wr_wptr] <= bus.io_write_data[p*WORD_WIDTH +: WORD_WIDTH];
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                wr_rptr <= '0;
                wr_wptr <= '0;
                wr_cnt  <= '0;
            end else begin
                if (wr_push) wr_wptr <= wr_wptr + PTR_ONE;
                if (wr_pop)  wr_rptr <= wr_rptr + PTR_ONE;
                case ({wr_push, wr_pop})
                    2'b10:   wr_cnt <= wr_cnt + CNT_ONE;
                    2'b01:   wr_cnt <= wr_cnt - CNT_ONE;
                    default: wr_cnt <= wr_cnt;
                endcase
            end
        end

        // A new error in the same cycle as err_clear keeps the bit set.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                underflow_q <= 1'b0;
                overflow_q  <= 1'b0;
            end else begin
                if (bus.io_rden[p] && rd_empty) underflow_q <= 1'b1;
                else if (bus.err_clear)         underflow_q <= 1'b0;
                if (bus.io_wren[p] && wr_full)  overflow_q  <= 1'b1;
                else if (bus.err_clear)         overflow_q  <= 1'b0;
            end
        end

        assign bus.err_underflow[p] = underflow_q;
        assign bus.err_overflow[p]  = overflow_q;
    end

endmodule

// File: tb/tb_io_port_fifo_bank.sv
// Bench for io_port_fifo_bank: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then biased random traffic.
module tb_io_port_fifo_bank;
    localparam int W  = 36;
    localparam int PC = 3;
    localparam int D  = 4;
    localparam int AW = 2;
    localparam int M  = 1;

    logic clock;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    io_port_fifo_bank_if #(.WORD_WIDTH(W), .PORT_COUNT(PC)) bus ();

    io_port_fifo_bank #(
        .WORD_WIDTH(W), .PORT_COUNT(PC), .FIFO_DEPTH(D),
        .FIFO_ADDR_WIDTH(AW), .WRITE_FULL_MARGIN(M)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per FIFO, sticky error flags.
    logic [W-1:0] rq [PC][$];
    logic [W-1:0] wq [PC][$];
    logic [PC-1:0] m_uf, m_of;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < PC; p++) begin
                rq[p].delete();
                wq[p].delete();
            end
            m_uf = '0;
            m_of = '0;
        end else begin
            for (int p = 0; p < PC; p++) begin
                int rn, wn;
                rn = rq[p].size();
                wn = wq[p].size();
                if (bus.io_rden[p] && rn > 0) void'(rq[p].pop_front());
                if (bus.ext_in_valid[p] && rn != D) rq[p].push_back(bus.ext_in_data[p*W +: W]);
                if (bus.ext_out_ready[p] && wn > 0) void'(wq[p].pop_front());
                if (bus.io_wren[p] && wn != D) wq[p].push_back(bus.io_write_data[p*W +: W]);
                if (bus.io_rden[p] && rn == 0)  m_uf[p] = 1'b1;
                else if (bus.err_clear)         m_uf[p] = 1'b0;
                if (bus.io_wren[p] && wn == D)  m_of[p] = 1'b1;
                else if (bus.err_clear)         m_of[p] = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            for (int p = 0; p < PC; p++) begin
                int rn, wn;
                rn = rq[p].size();
                wn = wq[p].size();
                chk($sformatf("read_EF[%0d]", p), 64'(bus.io_read_EF[p]), 64'(rn > 0));
                chk($sformatf("in_ready[%0d]", p), 64'(bus.ext_in_ready[p]), 64'(rn != D));
                chk($sformatf("write_EF[%0d]", p), 64'(bus.io_write_EF[p]), 64'((D - wn) <= M));
                chk($sformatf("out_valid[%0d]", p), 64'(bus.ext_out_valid[p]), 64'(wn > 0));
                chk($sformatf("err_uf[%0d]", p), 64'(bus.err_underflow[p]), 64'(m_uf[p]));
                chk($sformatf("err_of[%0d]", p), 64'(bus.err_overflow[p]), 64'(m_of[p]));
                if (rn > 0)
                    chk($sformatf("read_data[%0d]", p), 64'(bus.io_read_data[p*W +: W]), 64'(rq[p][0]));
                if (wn > 0)
                    chk($sformatf("out_data[%0d]", p), 64'(bus.ext_out_data[p*W +: W]), 64'(wq[p][0]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.io_rden       = '0;
        bus.io_wren       = '0;
        bus.io_write_data = '0;
        bus.ext_in_valid  = '0;
        bus.ext_in_data   = '0;
        bus.ext_out_ready = '0;
        bus.err_clear     = 1'b0;
    endtask

    function automatic logic [W-1:0] rdat(input int p);
        return bus.io_read_data[p*W +: W];
    endfunction

    function automatic logic [W-1:0] odat(input int p);
        return bus.ext_out_data[p*W +: W];
    endfunction

    initial begin
        int exp_head, next_in, guard;
        logic acc;

        reset_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        chk("rst_read_EF", 64'(bus.io_read_EF), 64'd0);
        chk("rst_in_ready", 64'(bus.ext_in_ready), 64'h7);
        chk("rst_write_EF", 64'(bus.io_write_EF), 64'd0);
        chk("rst_out_valid", 64'(bus.ext_out_valid), 64'd0);
        reset_n = 1'b1;
        tick();

        // Port 0 read stream: 1,2,3 then pop them back.
        for (int v = 1; v <= 3; v++) begin
            bus.ext_in_valid[0] = 1'b1;
            bus.ext_in_data[0 +: W] = W'(v);
            tick();
            if (v == 1) begin
                chk("t1_ef_after_first", 64'(bus.io_read_EF[0]), 64'd1);
                chk("t1_head_first", 64'(rdat(0)), 64'd1);
            end
        end
        bus.ext_in_valid[0] = 1'b0;
        bus.io_rden[0] = 1'b1;
        for (int v = 1; v <= 3; v++) begin
            chk("t1_pop_order", 64'(rdat(0)), 64'(v));
            tick();
        end
        bus.io_rden[0] = 1'b0;
        chk("t1_ef_empty", 64'(bus.io_read_EF[0]), 64'd0);

        // Port 1: fill, no full-bypass, then stream through the wrap.
        bus.ext_in_valid[1] = 1'b1;
        for (int v = 10; v < 14; v++) begin
            bus.ext_in_data[W +: W] = W'(v);
            tick();
        end
        chk("t2_full_ready", 64'(bus.ext_in_ready[1]), 64'd0);
        bus.io_rden[1] = 1'b1;
        bus.ext_in_data[W +: W] = W'(14);
        tick();
        chk("t2_ready_back", 64'(bus.ext_in_ready[1]), 64'd1);
        chk("t2_head_after_pop", 64'(rdat(1)), 64'd11);
        exp_head = 11;
        next_in  = 14;
        for (int i = 0; i < 12; i++) begin
            chk("t2_stream_head", 64'(rdat(1)), 64'(exp_head));
            acc = bus.ext_in_ready[1];
            tick();
            exp_head++;
            if (acc) begin
                next_in++;
                bus.ext_in_data[W +: W] = W'(next_in);
            end
        end
        bus.ext_in_valid[1] = 1'b0;
        guard = 0;
        while (bus.io_read_EF[1] && guard < 10) begin
            chk("t2_drain_head", 64'(rdat(1)), 64'(exp_head));
            tick();
            exp_head++;
            guard++;
        end
        bus.io_rden[1] = 1'b0;
        chk("t2_drained", 64'(bus.io_read_EF[1]), 64'd0);
        chk("t2_drain_end", 64'(exp_head), 64'(next_in));

        // Port 2 underflow and clear priority.
        bus.io_rden[2] = 1'b1;
        tick();
        bus.io_rden[2] = 1'b0;
        chk("t3_uf_set", 64'(bus.err_underflow[2]), 64'd1);
        tick();
        chk("t3_uf_sticky", 64'(bus.err_underflow[2]), 64'd1);
        bus.err_clear = 1'b1;
        tick();
        chk("t3_uf_cleared", 64'(bus.err_underflow[2]), 64'd0);
        bus.io_rden[2] = 1'b1;
        tick();
        chk("t3_uf_wins", 64'(bus.err_underflow[2]), 64'd1);
        bus.io_rden[2] = 1'b0;
        tick();
        bus.err_clear = 1'b0;
        chk("t3_uf_final_clear", 64'(bus.err_underflow[2]), 64'd0);

        // Write port 0 with margin 1: EF after three, fourth stored, fifth dropped.
        bus.io_wren[0] = 1'b1;
        for (int v = 0; v < 5; v++) begin
            bus.io_write_data[0 +: W] = W'(36'h100 + v);
            tick();
            if (v == 2) chk("t4_ef_margin", 64'(bus.io_write_EF[0]), 64'd1);
            if (v == 3) chk("t4_no_of_in_margin", 64'(bus.err_overflow[0]), 64'd0);
            if (v == 4) chk("t4_of_set", 64'(bus.err_overflow[0]), 64'd1);
        end
        bus.io_wren[0] = 1'b0;
        chk("t4_head", 64'(odat(0)), 64'h100);

        // Write port 1: A,B held, then drained back-to-back.
        bus.io_wren[1] = 1'b1;
        bus.io_write_data[W +: W] = W'(36'hA);
        tick();
        bus.io_write_data[W +: W] = W'(36'hB);
        tick();
        bus.io_wren[1] = 1'b0;
        tick();
        chk("t5_valid_held", 64'(bus.ext_out_valid[1]), 64'd1);
        chk("t5_data_A", 64'(odat(1)), 64'hA);
        bus.ext_out_ready = 3'b011;
        tick();
        chk("t5_data_B", 64'(odat(1)), 64'hB);
        tick();
        chk("t5_valid_drop", 64'(bus.ext_out_valid[1]), 64'd0);
        tick();
        tick();
        chk("t5_port0_empty", 64'(bus.ext_out_valid[0]), 64'd0);
        bus.ext_out_ready = '0;
        bus.err_clear = 1'b1;
        tick();
        bus.err_clear = 1'b0;

        // Async reset with two words in every FIFO and errors pending.
        bus.io_rden = 3'b111;
        tick();
        bus.io_rden = '0;
        bus.ext_in_valid = 3'b111;
        bus.io_wren = 3'b111;
        for (int i = 0; i < 2; i++) begin
            bus.ext_in_data   = {$urandom, $urandom, $urandom, $urandom};
            bus.io_write_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        idle_inputs();
        chk("t6_uf_before", 64'(bus.err_underflow), 64'h7);
        chk("t6_ef_before", 64'(bus.io_read_EF), 64'h7);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_read_EF", 64'(bus.io_read_EF), 64'd0);
        chk("t6_rst_out_valid", 64'(bus.ext_out_valid), 64'd0);
        chk("t6_rst_uf", 64'(bus.err_underflow), 64'd0);
        chk("t6_rst_in_ready", 64'(bus.ext_in_ready), 64'h7);
        chk("t6_rst_write_EF", 64'(bus.io_write_EF), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("t6_empty_read", 64'(bus.io_read_EF), 64'd0);
        chk("t6_empty_write", 64'(bus.ext_out_valid), 64'd0);

        // Biased random traffic; the compare process checks every cycle.
        for (int ph = 0; ph < 4; ph++) begin
            int push_pct, pop_pct;
            case (ph)
                0:       begin push_pct = 80; pop_pct = 20; end
                1:       begin push_pct = 20; pop_pct = 80; end
                2:       begin push_pct = 50; pop_pct = 50; end
                default: begin push_pct = 90; pop_pct = 90; end
            endcase
            for (int c = 0; c < 500; c++) begin
                for (int p = 0; p < PC; p++) begin
                    bus.ext_in_valid[p]  = ($urandom_range(0, 99) < push_pct);
                    bus.io_wren[p]       = ($urandom_range(0, 99) < push_pct);
                    bus.io_rden[p]       = ($urandom_range(0, 99) < pop_pct);
                    bus.ext_out_ready[p] = ($urandom_range(0, 99) < pop_pct);
                    bus.ext_in_data[p*W +: W]   = {4'($urandom), $urandom};
                    bus.io_write_data[p*W +: W] = {4'($urandom), $urandom};
                end
                bus.err_clear = ($urandom_range(0, 15) == 0);
                tick();
            end
        end
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
